// File: rtl/tlb_requester_if.sv
// rtl/tlb_requester_if.sv - request/response and miss/fill signal bundle for tlb_requester
interface tlb_requester_if;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        stall;
  logic        flush;
  logic        tlb_miss_detected;
  logic [31:0] miss_vaddr;
  logic        tlb_update;
  logic [31:0] physical_address;
  logic [15:0] miss_count;

  // Translation buffer side: serves the core, requests fills from the handler
  modport slave (
    input  req_valid, req_vaddr, flush, tlb_update, physical_address,
    output resp_valid, resp_paddr, stall, tlb_miss_detected, miss_vaddr, miss_count
  );

  // Environment side: core requester plus miss handler
  modport master (
    output req_valid, req_vaddr, flush, tlb_update, physical_address,
    input  resp_valid, resp_paddr, stall, tlb_miss_detected, miss_vaddr, miss_count
  );
endinterface

// File: rtl/tlb_requester.sv
// rtl/tlb_requester.sv - fully-associative TLB with miss pulse and handler fill
module tlb_requester #(
  parameter int ENTRIES   = 4,
  parameter int PAGE_BITS = 12
) (
  input  logic          clk,
  input  logic          reset,
  tlb_requester_if.slave bus
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int VPNW = 32 - PAGE_BITS;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [VPNW-1:0]     vpn_q [ENTRIES];
  logic [VPNW-1:0]     ppn_q [ENTRIES];
  logic [IDXW-1:0]     rr_q, rr_d;
  logic                drop_q, drop_d;
  logic                miss_q, miss_d;
  logic [31:0]         miss_vaddr_q, miss_vaddr_d;
  logic [15:0]         miss_count_q, miss_count_d;

  logic [VPNW-1:0]     req_vpn;
  logic                hit;
  logic [IDXW-1:0]     hit_idx;
  logic                start_miss;
  logic                install;
  logic                resp_valid;
  logic                stall;

  assign req_vpn = bus.req_vaddr[31:PAGE_BITS];

  // Associative lookup; scanning downward lets the lowest matching index win
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (vpn_q[i] == req_vpn)) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  // Next-state, handshake outputs and bookkeeping for the miss sequence
  always_comb begin
    state_d      = state_q;
    resp_valid   = 1'b0;
    stall        = 1'b0;
    start_miss   = 1'b0;
    install      = 1'b0;
    drop_d       = drop_q;
    valid_d      = valid_q;
    rr_d         = rr_q;
    miss_vaddr_d = miss_vaddr_q;
    miss_count_d = miss_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (hit) begin
            resp_valid = 1'b1;
          end else begin
            stall      = 1'b1;
            start_miss = 1'b1;
            state_d    = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus.tlb_update) begin
          // A flush since the miss (or right now) makes this fill stale
          install = !drop_q && !bus.flush;
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start_miss) begin
      miss_vaddr_d = bus.req_vaddr;
      if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
    end
    if (bus.flush && (state_q != S_IDLE) && !(state_q == S_WAIT && bus.tlb_update)) begin
      drop_d = 1'b1;
    end
    if (install) begin
      valid_d[rr_q] = 1'b1;
      rr_d          = rr_q + 1'b1;
    end
    if (bus.flush) valid_d = '0;
    miss_d = start_miss;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      rr_q         <= '0;
      drop_q       <= 1'b0;
      miss_q       <= 1'b0;
      miss_vaddr_q <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      rr_q         <= rr_d;
      drop_q       <= drop_d;
      miss_q       <= miss_d;
      miss_vaddr_q <= miss_vaddr_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Entry tag/data storage; qualified by valid_q so no reset is needed
  always_ff @(posedge clk) begin
    if (install) begin
      vpn_q[rr_q] <= miss_vaddr_q[31:PAGE_BITS];
      ppn_q[rr_q] <= bus.physical_address[31:PAGE_BITS];
    end
  end

  assign bus.resp_valid        = resp_valid;
  assign bus.resp_paddr        = resp_valid ? {ppn_q[hit_idx], bus.req_vaddr[PAGE_BITS-1:0]} : 32'd0;
  assign bus.stall             = stall;
  assign bus.tlb_miss_detected = miss_q;
  assign bus.miss_vaddr        = miss_vaddr_q;
  assign bus.miss_count        = miss_count_q;
endmodule
